// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared definitions for the data memory controller
//   - RISC-V funct3 size codes for loads/stores
//   - lane_strobe(): byte-lane write strobe from size and address offset
//   - req_legal(): size/offset/direction legality of a port A request
//   - clr_state_t : states of the optional power-up clear sequencer
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_t;

    // Byte lanes touched by an access of the given size at offset off.
    function automatic logic [3:0] lane_strobe(input logic [2:0] funct3,
                                               input logic [1:0] off);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Known size code, naturally aligned, and no unsigned variant on stores.
    function automatic logic req_legal(input logic [2:0] funct3,
                                       input logic       we,
                                       input logic [1:0] off);
        logic ok;
        case (funct3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        if (we && funct3[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if : bus bundle for the data memory controller
//   Port A (CPU load/store): a_valid/a_ready handshake, a_we, a_funct3,
//     a_addr, a_wdata in; a_rvalid, a_rdata, a_misalign out.
//   Port B (debug read): b_addr in, b_rdata out.
//   modport master : requester side (CPU / testbench)
//   modport slave  : memory side (data_mem_ctrl)
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              a_valid;
    logic              a_ready;
    logic              a_we;
    logic [2:0]        a_funct3;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              a_misalign;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_valid, a_we, a_funct3, a_addr, a_wdata, b_addr,
        input  a_ready, a_rvalid, a_rdata, a_misalign, b_rdata
    );

    modport slave (
        input  a_valid, a_we, a_funct3, a_addr, a_wdata, b_addr,
        output a_ready, a_rvalid, a_rdata, a_misalign, b_rdata
    );
endinterface

// File: rtl/data_mem_ctrl_load_align.sv
// ---------------------------------------------------------------------------
// dmem_load_align : combinational load data extraction
//   i_word   : full memory word
//   i_funct3 : RISC-V load size code (LB/LH/LW/LBU/LHU)
//   i_offset : byte offset of the access within the word
//   o_data   : selected byte/half moved to bit 0, sign or zero extended;
//              the whole word for LW (and for any other code)
// ---------------------------------------------------------------------------
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_offset,
    output logic [DATA_W-1:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_B:    o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_H:    o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_BU:   o_data = {{(DATA_W-8){1'b0}}, w_byte};
            F3_HU:   o_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl : RV32 data memory, one load/store port and one debug port
//   clk  : clock, all state on the rising edge
//   rstn : asynchronous active-low reset of the output/control registers
//   bus  : data_mem_ctrl_if.slave
//          port A - byte/half/word load/store, 1-cycle load latency,
//                   a_misalign pulse for misaligned or illegal requests
//          port B - registered read of word b_addr every cycle, with
//                   write-through bypass of a same-edge port A store
// Optional build macro DMEM_INIT_CLEAR_EN: after reset a clear sequencer
// zeroes every word (one per cycle) while holding a_ready low.
// Array contents themselves are never reset.
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rstn,
    data_mem_ctrl_if.slave  bus
);
    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_a_rvalid;
    logic              r_a_misalign;
    logic [DATA_W-1:0] r_a_word;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_off;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_ready;
    logic              w_clearing;
    logic [IDX_W-1:0]  w_clr_idx;
    logic              w_accept;
    logic              w_legal;
    logic              w_store;
    logic              w_load;
    logic [IDX_W-1:0]  w_a_idx;
    logic [IDX_W-1:0]  w_b_idx;
    logic [LANES-1:0]  w_a_strb;
    logic [DATA_W-1:0] w_a_wdata_rep;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [LANES-1:0]  w_wr_strb;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_b_merged;
    logic [DATA_W-1:0] w_a_rdata;
    logic              w_unused;

    // Word index keeps only the low bits, so addresses wrap modulo DEPTH.
    assign w_a_idx  = bus.a_addr[IDX_W+1:2];
    assign w_b_idx  = bus.b_addr[IDX_W+1:2];
    assign w_unused = ^{bus.a_addr, bus.b_addr};

    assign w_accept = bus.a_valid & w_ready;
    assign w_legal  = req_legal(bus.a_funct3, bus.a_we, bus.a_addr[1:0]);
    assign w_store  = w_accept & w_legal & bus.a_we;
    assign w_load   = w_accept & w_legal & ~bus.a_we;
    assign w_a_strb = lane_strobe(bus.a_funct3, bus.a_addr[1:0]);

    // Right-aligned store data replicated so every lane carries its byte.
    always_comb begin
        case (bus.a_funct3[1:0])
            2'b00:   w_a_wdata_rep = {LANES{bus.a_wdata[7:0]}};
            2'b01:   w_a_wdata_rep = {(LANES/2){bus.a_wdata[15:0]}};
            default: w_a_wdata_rep = bus.a_wdata;
        endcase
    end

`ifdef DMEM_INIT_CLEAR_EN
    clr_state_t       r_state;
    clr_state_t       w_state_next;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [IDX_W-1:0] w_clr_cnt_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clearing     = 1'b0;
        w_ready        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing     = 1'b1;
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_ready = 1'b1;
        endcase
    end

    assign w_clr_idx = r_clr_cnt;
`else
    assign w_clearing = 1'b0;
    assign w_ready    = 1'b1;
    assign w_clr_idx  = '0;
`endif

    // Single write port shared by the clear sequencer and port A stores;
    // they never overlap because a_ready is low while clearing.
    assign w_wr_en   = w_clearing | w_store;
    assign w_wr_idx  = w_clearing ? w_clr_idx : w_a_idx;
    assign w_wr_strb = w_clearing ? {LANES{1'b1}} : w_a_strb;
    assign w_wr_data = w_clearing ? '0 : w_a_wdata_rep;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int li = 0; li < LANES; li++) begin
                if (w_wr_strb[li]) begin
                    r_mem[w_wr_idx][li*8 +: 8] <= w_wr_data[li*8 +: 8];
                end
            end
        end
    end

    // Port B sees the bytes being written at the same edge.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_b_bypass
        assign w_b_merged[gi*8 +: 8] =
            (w_wr_en && w_wr_strb[gi] && (w_wr_idx == w_b_idx)) ?
            w_wr_data[gi*8 +: 8] : r_mem[w_b_idx][gi*8 +: 8];
    end

    // Load word is captured read-first and held until the next legal load,
    // so a_rdata stays stable between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a_rvalid   <= 1'b0;
            r_a_misalign <= 1'b0;
            r_a_word     <= '0;
            r_ld_funct3  <= F3_W;
            r_ld_off     <= 2'b00;
            r_b_rdata    <= '0;
        end else begin
            r_a_rvalid   <= w_load;
            r_a_misalign <= w_accept & ~w_legal;
            if (w_load) begin
                r_a_word    <= r_mem[w_a_idx];
                r_ld_funct3 <= bus.a_funct3;
                r_ld_off    <= bus.a_addr[1:0];
            end
            r_b_rdata <= w_clearing ? '0 : w_b_merged;
        end
    end

    dmem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .i_word   (r_a_word),
        .i_funct3 (r_ld_funct3),
        .i_offset (r_ld_off),
        .o_data   (w_a_rdata)
    );

    assign bus.a_ready    = w_ready;
    assign bus.a_rvalid   = r_a_rvalid;
    assign bus.a_rdata    = w_a_rdata;
    assign bus.a_misalign = r_a_misalign;
    assign bus.b_rdata    = r_b_rdata;
endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for data_mem_ctrl: a byte-addressed memory model produces
// expected port A responses and port B words; a monitor compares them.
module tb_data_mem_ctrl;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 12;
    localparam int DEPTH     = 256;
    localparam int MEM_BYTES = DEPTH * 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_mem_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          due;
        int          addr;
    } a_exp_t;

    typedef struct {
        logic [31:0] data;
        int          due;
        int          addr;
    } b_exp_t;

    logic [7:0]  m_mem   [MEM_BYTES];
    bit          m_known [MEM_BYTES];
    a_exp_t      q_a[$];
    b_exp_t      q_b[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit we, input logic [2:0] f3, input int addr);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return (addr % m_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int addr);
        logic [31:0] val;
        int          sz;
        sz  = m_size(f3);
        val = 32'h0;
        for (int i = 0; i < sz; i++)
            val = val | (32'(m_mem[(addr + i) % MEM_BYTES]) << (8 * i));
        if (sz < 4 && !f3[2] && val[8*sz-1])
            val = val | ~((32'h1 << (8 * sz)) - 32'h1);
        return val;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and record what the DUT must answer.
    task automatic issue(input bit v, input bit we, input logic [2:0] f3,
                         input int addr, input logic [31:0] wdata, input int baddr);
        int waited;
        int wb;
        bit known;
        a_exp_t ea;
        b_exp_t eb;
        waited = 0;
        @(posedge clk); #1;
        while (v && !bus.a_ready && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 1000) chk("a_ready_timeout", 32'(bus.a_ready), 32'h1);
        bus.a_valid  = v;
        bus.a_we     = we;
        bus.a_funct3 = f3;
        bus.a_addr   = ADDR_W'(addr);
        bus.a_wdata  = wdata;
        bus.b_addr   = ADDR_W'(baddr);
        if (v) begin
            addr = addr % MEM_BYTES;
            if (!m_legal(we, f3, addr)) begin
                ea.is_load = 1'b0; ea.data = 32'h0; ea.due = cyc + 1; ea.addr = addr;
                q_a.push_back(ea);
            end else if (we) begin
                for (int i = 0; i < m_size(f3); i++) begin
                    m_mem[(addr + i) % MEM_BYTES]   = wdata[8*i +: 8];
                    m_known[(addr + i) % MEM_BYTES] = 1'b1;
                end
                $display("store f3=%0d addr=%h data=%h", f3, addr, wdata);
            end else begin
                ea.is_load = 1'b1; ea.data = m_load(f3, addr); ea.due = cyc + 1; ea.addr = addr;
                q_a.push_back(ea);
            end
        end
        wb = (baddr % MEM_BYTES) & ~3;
        known = m_known[wb] && m_known[wb+1] && m_known[wb+2] && m_known[wb+3];
        if (known) begin
            eb.data = m_load(3'b010, wb); eb.due = cyc + 1; eb.addr = wb;
            q_b.push_back(eb);
        end
    endtask

    // Monitor: consumes expectations as the DUT presents responses.
    initial begin
        a_exp_t ea;
        b_exp_t eb;
        forever begin
            @(negedge clk);
            if (!rstn) continue;
            if (bus.a_rvalid || bus.a_misalign) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected rvalid=%0b misalign=%0b rdata=%h required=none",
                             bus.a_rvalid, bus.a_misalign, bus.a_rdata);
                end else begin
                    ea = q_a.pop_front();
                    if (ea.due != cyc || bus.a_rvalid != ea.is_load || bus.a_misalign == ea.is_load
                        || (ea.is_load && bus.a_rdata !== ea.data)) begin
                        errors++;
                        $display("FAIL a_resp addr=%h cyc=%0d due=%0d rvalid=%0b misalign=%0b rdata=%h required load=%0b data=%h",
                                 ea.addr, cyc, ea.due, bus.a_rvalid, bus.a_misalign, bus.a_rdata, ea.is_load, ea.data);
                    end else begin
                        $display("resp addr=%h load=%0b data=%h", ea.addr, ea.is_load, bus.a_rdata);
                    end
                    if (ea.is_load) last_rdata = ea.data;
                end
            end else begin
                while (q_a.size() > 0 && q_a[0].due <= cyc) begin
                    ea = q_a.pop_front();
                    checks++; errors++;
                    $display("FAIL a_missing addr=%h actual=no_response required load=%0b data=%h",
                             ea.addr, ea.is_load, ea.data);
                end
                chk("a_rdata_hold", bus.a_rdata, last_rdata);
            end
            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                eb = q_b.pop_front();
                chk($sformatf("b_rdata@%h", eb.addr), bus.b_rdata, eb.data);
            end
        end
    end

`ifdef DMEM_INIT_CLEAR_EN
    task automatic count_clear(input int stop_at, output int n);
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (bus.a_ready) break;
            n++;
            if (n == stop_at) break;
        end
    endtask
`endif

    initial begin
        int n;
        bit v, we;
        logic [2:0] f3;
        int addr, baddr;
        bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_funct3 = 3'b010;
        bus.a_addr = '0; bus.a_wdata = '0; bus.b_addr = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", 32'(bus.a_rvalid), 32'h0);
        chk("reset_rdata", bus.a_rdata, 32'h0);
        chk("reset_misalign", 32'(bus.a_misalign), 32'h0);
        chk("reset_b_rdata", bus.b_rdata, 32'h0);
        #2 rstn = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
        count_clear(0, n);
        chk("clear_cycles", 32'(n), 32'd256);
        @(posedge clk); #1 rstn = 1'b0; #2 rstn = 1'b1;
        count_clear(100, n);
        @(posedge clk); #1 rstn = 1'b0; #2 rstn = 1'b1;
        count_clear(0, n);
        chk("clear_restart_cycles", 32'(n), 32'd256);
        for (int i = 0; i < MEM_BYTES; i++) begin
            m_mem[i] = 8'h0; m_known[i] = 1'b1;
        end
        for (int i = 0; i < 8; i++)
            issue(1, 0, 3'b010, $urandom_range(0, 1023) * 4, 32'h0, $urandom_range(0, 4095));
`else
        #1 chk("ready_after_reset", 32'(bus.a_ready), 32'h1);
`endif
        for (int w = 0; w < DEPTH; w++)
            issue(1, 1, 3'b010, w * 4, $urandom, $urandom_range(0, 4095));
        // Directed scenarios
        issue(1, 1, 3'b010, 12'h010, 32'hDEADBEEF, 12'h010);
        issue(1, 0, 3'b010, 12'h010, 32'h0, 12'h010);
        issue(1, 1, 3'b000, 12'h013, 32'h00000080, 12'h010);
        issue(1, 0, 3'b000, 12'h013, 32'h0, 12'h000);
        issue(1, 0, 3'b100, 12'h013, 32'h0, 12'h000);
        issue(1, 0, 3'b010, 12'h010, 32'h0, 12'h010);
        issue(1, 1, 3'b001, 12'h021, 32'h00001234, 12'h020);
        issue(1, 0, 3'b010, 12'h020, 32'h0, 12'h020);
        issue(1, 0, 3'b010, 12'h012, 32'h0, 12'h020);
        issue(1, 1, 3'b010, 12'h040, 32'hA5A5A5A5, 12'h040);
        issue(1, 1, 3'b010, 12'h400, 32'h00000011, 12'h000);
        issue(1, 0, 3'b010, 12'h000, 32'h0, 12'h400);
        issue(0, 0, 3'b010, 0, 32'h0, 12'h000);
        // Randomized traffic, biased to a small window for hazards/bypass
        for (int i = 0; i < 2000; i++) begin
            v     = ($urandom_range(0, 9) < 8);
            we    = $urandom_range(0, 1);
            f3    = 3'($urandom_range(0, 7));
            addr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 63);
            baddr = ($urandom_range(0, 1) == 1) ? addr : $urandom_range(0, 4095);
            issue(v, we, f3, addr, $urandom, baddr);
        end
        issue(0, 0, 3'b010, 0, 32'h0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("q_a_drained", 32'(q_a.size()), 32'h0);
        chk("q_b_drained", 32'(q_b.size()), 32'h0);
        // Asynchronous reset mid-operation clears outputs immediately
        @(posedge clk); #2 rstn = 1'b0; #1;
        chk("async_reset_rvalid", 32'(bus.a_rvalid), 32'h0);
        chk("async_reset_rdata", bus.a_rdata, 32'h0);
        chk("async_reset_misalign", 32'(bus.a_misalign), 32'h0);
        chk("async_reset_b_rdata", bus.b_rdata, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
